// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
package dmem_arb_pkg;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        ACK     = 3'd4
    } state_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the port that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates CPU (p0) and debug/DMA (p1) accesses onto a single stalling data memory.
// Handshake: pN_req is held until a one-cycle pN_ack; pN_rdata is valid while pN_ack=1.
module data_mem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_sign_mask,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_sign_mask,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [MASK_W-1:0] mem_sign_mask,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_clk_stall,
    output logic              err,
    output state_t            fsm_state
);

    state_t            state, state_next;
    logic [1:0]        grant;
    logic              grant_q;
    logic              we_q;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              timeout_hit;
    logic              latch;
    logic              done;
    logic              abort;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [MASK_W-1:0] sel_mask;

    rr_arb2 u_arb (
        .req        ({p1_req, p0_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel_we      = grant[1] ? p1_we        : p0_we;
    assign sel_addr    = grant[1] ? p1_addr      : p0_addr;
    assign sel_wdata   = grant[1] ? p1_wdata     : p0_wdata;
    assign sel_mask    = grant[1] ? p1_sign_mask : p0_sign_mask;
    assign cnt_inc     = wait_cnt + CNT_W'(1);
    assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));
    assign fsm_state   = state;

    // An abort leaves through ACK so the requester's still-high req is not re-sampled.
    always_comb begin
        state_next = state;
        latch      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (grant != 2'b00) begin
                    latch      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_HI;
            WAIT_HI: begin
                if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = ACK;
                end else if (mem_clk_stall) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = ACK;
                end else if (!mem_clk_stall) begin
                    done       = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q        <= 1'b0;
            we_q           <= 1'b0;
            last_grant     <= 1'b1;
            wait_cnt       <= '0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
            p0_ack         <= 1'b0;
            p1_ack         <= 1'b0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
            err            <= 1'b0;
        end else begin
            // Strobes are high only during ISSUE, i.e. the cycle after the grant.
            mem_memread  <= latch & ~sel_we;
            mem_memwrite <= latch & sel_we;
            if (latch) begin
                grant_q        <= grant[1];
                we_q           <= sel_we;
                mem_addr       <= sel_addr;
                mem_write_data <= sel_wdata;
                mem_sign_mask  <= sel_mask;
            end

            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT_HI || state == WAIT_LO) begin
                wait_cnt <= cnt_inc;
            end

            p0_ack <= (done | abort) & ~grant_q;
            p1_ack <= (done | abort) & grant_q;

            if (abort) begin
                err <= 1'b1;
                if (grant_q) p1_rdata <= '0;
                else         p0_rdata <= '0;
            end else if (done && !we_q) begin
                if (grant_q) p1_rdata <= mem_read_data;
                else         p0_rdata <= mem_read_data;
            end

            if (state == ACK) begin
                last_grant <= grant_q;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter against a memory that stalls for two cycles per access.
module tb_data_mem_arbiter;
    import dmem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        p0_req = 1'b0, p0_we = 1'b0;
    logic [11:0] p0_addr = '0;
    logic [31:0] p0_wdata = '0;
    logic [3:0]  p0_sign_mask = '0;
    logic        p0_ack;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_we = 1'b0;
    logic [11:0] p1_addr = '0;
    logic [31:0] p1_wdata = '0;
    logic [3:0]  p1_sign_mask = '0;
    logic        p1_ack;
    logic [31:0] p1_rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread, mem_memwrite;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;
    logic        err;
    state_t      fsm_state;

    int checks = 0;
    int errors = 0;

    // ---- clock / reset ----
    always #5 clk = ~clk;

    // ---- memory model: stall rises the cycle after a strobe and lasts two cycles ----
    logic        stuck = 1'b0;
    int          stall_cnt = 0;
    logic [31:0] rd_val = '0;
    always @(posedge clk) begin
        if (mem_memread || mem_memwrite) stall_cnt <= 2;
        else if (stall_cnt > 0)          stall_cnt <= stall_cnt - 1;
    end
    assign mem_clk_stall = stuck || (stall_cnt != 0);
    assign mem_read_data = rd_val;

    data_mem_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_sign_mask(p0_sign_mask), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_sign_mask(p1_sign_mask), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_sign_mask(mem_sign_mask),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall),
        .err(err), .fsm_state(fsm_state)
    );

    // ---- driver ----
    logic [7:0]  rd_bits, wr_bits, ack_bits, oth_ack_bits;
    logic [11:0] cap_addr;
    logic [31:0] cap_wdata, cap_rdata;
    logic [3:0]  cap_mask;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request at cycle 0, observe cycles 1..7; port inputs are scrambled after the grant.
    task automatic drive_txn(input logic port, input logic we, input logic [11:0] addr,
                             input logic [31:0] wd, input logic [3:0] mask, input logic [31:0] rdv);
        logic ack_now;
        rd_val = rdv;
        rd_bits = '0; wr_bits = '0; ack_bits = '0; oth_ack_bits = '0;
        cap_addr = '0; cap_wdata = '0; cap_mask = '0; cap_rdata = '0;
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_sign_mask = mask; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_sign_mask = mask; p0_req = 1'b1;
        end
        for (int c = 1; c < 8; c++) begin
            tick();
            rd_bits[c]      = mem_memread;
            wr_bits[c]      = mem_memwrite;
            ack_now         = port ? p1_ack : p0_ack;
            ack_bits[c]     = ack_now;
            oth_ack_bits[c] = port ? p0_ack : p1_ack;
            if (c == 1) begin
                cap_addr = mem_addr; cap_wdata = mem_write_data; cap_mask = mem_sign_mask;
                if (port) begin
                    p1_we = ~we; p1_addr = ~addr; p1_wdata = ~wd; p1_sign_mask = ~mask;
                end else begin
                    p0_we = ~we; p0_addr = ~addr; p0_wdata = ~wd; p0_sign_mask = ~mask;
                end
            end
            if (ack_now) begin
                cap_rdata = port ? p1_rdata : p0_rdata;
                if (port) p1_req = 1'b0;
                else      p0_req = 1'b0;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    // ---- tests ----
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", fsm_state, IDLE); end
        checks++; if ({mem_memread, mem_memwrite} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {mem_memread, mem_memwrite}); end
        checks++; if ({p0_ack, p1_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks got %b want 00", {p0_ack, p1_ack}); end
        checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h %h want 0 0", p0_rdata, p1_rdata); end
        checks++; if (mem_addr !== 12'h0 || mem_write_data !== 32'h0 || mem_sign_mask !== 4'h0) begin errors++; $display("FAIL reset_mem_fields got %h %h %h want 0", mem_addr, mem_write_data, mem_sign_mask); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_p0();
        drive_txn(1'b0, 1'b0, 12'h004, 32'h0, 4'h2, 32'hDEAD_BEEF);
        checks++; if (rd_bits !== 8'h02) begin errors++; $display("FAIL p0_read_strobe got %b want %b", rd_bits, 8'h02); end
        checks++; if (wr_bits !== 8'h00) begin errors++; $display("FAIL p0_read_no_write got %b want 0", wr_bits); end
        checks++; if (ack_bits !== 8'h20) begin errors++; $display("FAIL p0_read_ack got %b want %b", ack_bits, 8'h20); end
        checks++; if (oth_ack_bits !== 8'h00) begin errors++; $display("FAIL p0_read_other_ack got %b want 0", oth_ack_bits); end
        checks++; if (cap_addr !== 12'h004 || cap_mask !== 4'h2) begin errors++; $display("FAIL p0_read_fields got %h %h want 004 2", cap_addr, cap_mask); end
        checks++; if (cap_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p0_read_rdata got %h want deadbeef", cap_rdata); end
        checks++; if (mem_addr !== 12'h004) begin errors++; $display("FAIL p0_read_addr_held got %h want 004", mem_addr); end
        checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p0_rdata_hold got %h want deadbeef", p0_rdata); end
    endtask

    task automatic test_read_p1();
        drive_txn(1'b1, 1'b0, 12'h008, 32'h0, 4'h0, 32'hCAFE_F00D);
        checks++; if (ack_bits !== 8'h20) begin errors++; $display("FAIL p1_read_ack got %b want %b", ack_bits, 8'h20); end
        checks++; if (cap_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL p1_read_rdata got %h want cafef00d", cap_rdata); end
        checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL p1_read_p0_untouched got %h want deadbeef", p0_rdata); end
    endtask

    task automatic test_write_p1();
        drive_txn(1'b1, 1'b1, 12'h010, 32'h0000_00A5, 4'h4, 32'h1234_5678);
        checks++; if (wr_bits !== 8'h02) begin errors++; $display("FAIL p1_write_strobe got %b want %b", wr_bits, 8'h02); end
        checks++; if (rd_bits !== 8'h00) begin errors++; $display("FAIL p1_write_no_read got %b want 0", rd_bits); end
        checks++; if (cap_addr !== 12'h010 || cap_wdata !== 32'hA5 || cap_mask !== 4'h4) begin errors++; $display("FAIL p1_write_fields got %h %h %h want 010 a5 4", cap_addr, cap_wdata, cap_mask); end
        checks++; if (ack_bits !== 8'h20) begin errors++; $display("FAIL p1_write_ack got %b want %b", ack_bits, 8'h20); end
        checks++; if (cap_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL p1_write_rdata_kept got %h want cafef00d", cap_rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a0, a1, strb;
        logic [3:0]  gseq;
        int          gi;
        a0 = '0; a1 = '0; strb = '0; gseq = '0; gi = 0;
        rd_val = 32'h1111_1111;
        p0_we = 1'b0; p0_addr = 12'h020; p0_req = 1'b1;
        p1_we = 1'b0; p1_addr = 12'h024; p1_req = 1'b1;
        for (int c = 1; c < 24; c++) begin
            tick();
            a0[c] = p0_ack;
            a1[c] = p1_ack;
            strb[c] = mem_memread;
            if (mem_memread) begin
                if (gi < 4) gseq[gi] = (mem_addr == 12'h024);
                gi++;
            end
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        tick();
        tick();
        checks++; if (a0 !== 32'h0002_0020) begin errors++; $display("FAIL b2b_p0_acks got %h want 00020020", a0); end
        checks++; if (a1 !== 32'h0080_0800) begin errors++; $display("FAIL b2b_p1_acks got %h want 00800800", a1); end
        checks++; if (strb !== 32'h0008_2082) begin errors++; $display("FAIL b2b_strobes got %h want 00082082", strb); end
        checks++; if (gseq !== 4'b1010 || gi != 4) begin errors++; $display("FAIL b2b_grant_order got %b/%0d want 1010/4", gseq, gi); end
    endtask

    task automatic test_mid_arrival();
        logic [15:0] a0, a1;
        logic [11:0] second_addr;
        a0 = '0; a1 = '0; second_addr = '0;
        rd_val = 32'h2222_2222;
        p0_we = 1'b0; p0_addr = 12'h030; p0_req = 1'b1;
        for (int c = 1; c < 15; c++) begin
            tick();
            if (c == 2) begin
                p1_we = 1'b0; p1_addr = 12'h034; p1_req = 1'b1;
            end
            if (c == 7) second_addr = mem_addr;
            a0[c] = p0_ack;
            a1[c] = p1_ack;
            if (p0_ack) p0_req = 1'b0;
            if (p1_ack) p1_req = 1'b0;
        end
        p0_req = 1'b0;
        p1_req = 1'b0;
        checks++; if (a0 !== 16'h0020) begin errors++; $display("FAIL mid_p0_ack got %h want 0020", a0); end
        checks++; if (a1 !== 16'h0800) begin errors++; $display("FAIL mid_p1_ack got %h want 0800", a1); end
        checks++; if (second_addr !== 12'h034) begin errors++; $display("FAIL mid_p1_addr got %h want 034", second_addr); end
    endtask

    task automatic test_timeout();
        logic [31:0] a0;
        logic        err16, err17;
        logic [31:0] rd_at_ack;
        a0 = '0; err16 = 1'bx; err17 = 1'bx; rd_at_ack = 32'hFFFF_FFFF;
        stuck = 1'b1;
        rd_val = 32'h5555_5555;
        p0_we = 1'b0; p0_addr = 12'h040; p0_req = 1'b1;
        for (int c = 1; c < 21; c++) begin
            tick();
            a0[c] = p0_ack;
            if (c == 16) err16 = err;
            if (c == 17) err17 = err;
            if (p0_ack) begin
                rd_at_ack = p0_rdata;
                p0_req = 1'b0;
            end
        end
        p0_req = 1'b0;
        stuck = 1'b0;
        tick();
        checks++; if (a0 !== 32'h0002_0000) begin errors++; $display("FAIL timeout_ack got %h want 00020000", a0); end
        checks++; if (err16 !== 1'b0) begin errors++; $display("FAIL timeout_err_early got %b want 0", err16); end
        checks++; if (err17 !== 1'b1) begin errors++; $display("FAIL timeout_err got %b want 1", err17); end
        checks++; if (rd_at_ack !== 32'h0) begin errors++; $display("FAIL timeout_rdata got %h want 0", rd_at_ack); end
        drive_txn(1'b0, 1'b0, 12'h044, 32'h0, 4'h0, 32'h0BAD_F00D);
        checks++; if (ack_bits !== 8'h20) begin errors++; $display("FAIL after_timeout_ack got %b want %b", ack_bits, 8'h20); end
        checks++; if (cap_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL after_timeout_rdata got %h want 0badf00d", cap_rdata); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        logic any_ack;
        state_t st3;
        any_ack = 1'b0;
        p0_we = 1'b1; p0_addr = 12'h050; p0_wdata = 32'h0000_0077; p0_sign_mask = 4'hF; p0_req = 1'b1;
        tick();
        tick();
        tick();
        st3 = fsm_state;
        rst = 1'b1;
        p0_req = 1'b0;
        tick();
        checks++; if (st3 !== WAIT_LO) begin errors++; $display("FAIL rstmid_precondition got %0d want %0d", st3, WAIT_LO); end
        checks++; if (fsm_state !== IDLE) begin errors++; $display("FAIL rstmid_state got %0d want %0d", fsm_state, IDLE); end
        checks++; if ({p0_ack, p1_ack, mem_memread, mem_memwrite} !== 4'b0) begin errors++; $display("FAIL rstmid_pulses got %b want 0000", {p0_ack, p1_ack, mem_memread, mem_memwrite}); end
        checks++; if (mem_addr !== 12'h0 || mem_write_data !== 32'h0 || mem_sign_mask !== 4'h0) begin errors++; $display("FAIL rstmid_mem_fields got %h %h %h want 0", mem_addr, mem_write_data, mem_sign_mask); end
        checks++; if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL rstmid_rdata_err got %h %h %b want 0 0 0", p0_rdata, p1_rdata, err); end
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            any_ack = any_ack | p0_ack | p1_ack;
        end
        checks++; if (any_ack !== 1'b0) begin errors++; $display("FAIL rstmid_no_ack got %b want 0", any_ack); end
        drive_txn(1'b1, 1'b0, 12'h060, 32'h0, 4'h1, 32'h4444_4444);
        checks++; if (ack_bits !== 8'h20 || oth_ack_bits !== 8'h00) begin errors++; $display("FAIL rstmid_p1_ack got %b/%b want %b/0", ack_bits, oth_ack_bits, 8'h20); end
        checks++; if (cap_addr !== 12'h060 || cap_rdata !== 32'h4444_4444) begin errors++; $display("FAIL rstmid_p1_data got %h %h want 060 44444444", cap_addr, cap_rdata); end
    endtask

    initial begin
        test_reset();
        test_read_p0();
        test_read_p1();
        test_write_p1();
        test_back_to_back();
        test_mid_arrival();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
